// File: rtl/fxp32_dot_seq.sv
// ----------------------------------------------------------------------------
// fxp32_dot_seq
//
// Operand sequencer and result collector sitting on the initiator side of an
// fxp32_mac. A vector of Q16.16 operand pairs arrives on a valid/ready stream
// framed by s_last. The block clears the MAC, feeds it one pair per accepted
// beat, drains the MAC pipeline after the final pair, then offers the dot
// product and pair count on a valid/ready result port.
//
// Optional feature macro: FXP32_DOT_MAXLEN_EN
//   defined   : a vector is cut once MAX_LEN pairs have been accepted and the
//               result is flagged with m_trunc; remaining pairs form a new vector
//   undefined : no length limit, m_trunc is tied low, MAX_LEN is ignored
//
// Parameters
//   MAC_LAT   latency of fxp32_mac (operands to out_c)
//   CNT_W     width of the pair counter (saturates, never wraps)
//   MAX_LEN   vector length limit (only with FXP32_DOT_MAXLEN_EN)
//
// Ports
//   clk, rst               rising-edge clock, synchronous active-high reset
//   s_valid/s_ready        operand stream handshake
//   s_a, s_b, s_last       operand pair (Q16.16) and end-of-vector flag
//   mac_prstn, mac_acc     MAC product-pipe clear (active low), accumulate enable
//   mac_a, mac_b           operands driven into the MAC
//   mac_c                  MAC accumulator output
//   m_valid/m_ready        result handshake
//   m_result, m_count      captured dot product and number of pairs
//   m_trunc                result was cut at MAX_LEN
//   busy                   low only while idle in RUN with no pairs taken
// ----------------------------------------------------------------------------
module fxp32_dot_seq #(
    parameter int MAC_LAT = 2,
    parameter int CNT_W   = 16,
    parameter int MAX_LEN = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_a,
    input  logic [31:0]      s_b,
    input  logic             s_last,
    output logic             mac_prstn,
    output logic             mac_acc,
    output logic [31:0]      mac_a,
    output logic [31:0]      mac_b,
    input  logic [31:0]      mac_c,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_result,
    output logic [CNT_W-1:0] m_count,
    output logic             m_trunc,
    output logic             busy
);

    // The phase counter has to reach MAC_LAT+1 (last DRAIN cycle).
    localparam int              PH_W       = $clog2(MAC_LAT + 2) + 1;
    localparam logic [PH_W-1:0] CLR_LAST   = PH_W'(MAC_LAT);
    localparam logic [PH_W-1:0] DRAIN_LAST = PH_W'(MAC_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_CLR,
        ST_RUN,
        ST_DRAIN,
        ST_OUT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PH_W-1:0]   r_phase;
    logic [PH_W-1:0]   w_phase_nxt;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [CNT_W-1:0]  w_count_inc;

    logic              w_accept;
    logic              w_len_hit;
    logic              w_end;
    logic              w_capture;
    logic              w_result_taken;

    logic              r_s_ready;
    logic              r_mac_prstn;
    logic              r_mac_acc;
    logic [31:0]       r_mac_a;
    logic [31:0]       r_mac_b;
    logic              r_m_valid;
    logic [31:0]       r_m_result;
    logic [CNT_W-1:0]  r_m_count;
    logic              r_busy;

    logic              w_s_ready_nxt;
    logic              w_mac_prstn_nxt;
    logic              w_mac_acc_nxt;
    logic [31:0]       w_mac_a_nxt;
    logic [31:0]       w_mac_b_nxt;
    logic              w_m_valid_nxt;
    logic [31:0]       w_m_result_nxt;
    logic [CNT_W-1:0]  w_m_count_nxt;
    logic              w_busy_nxt;

    // s_ready is registered and only ever high in RUN, so it alone qualifies
    // an accept. The pair counter saturates instead of wrapping.
    assign w_accept       = s_valid & r_s_ready;
    assign w_count_inc    = (r_count == CNT_MAX) ? r_count : r_count + CNT_W'(1);
    assign w_result_taken = r_m_valid & m_ready;

`ifdef FXP32_DOT_MAXLEN_EN
    // Reaching the length limit closes the vector just like s_last would.
    assign w_len_hit = (w_count_inc == CNT_W'(MAX_LEN));
`else
    logic w_unused_maxlen;

    // Without the limit feature MAX_LEN has no function; it is only referenced
    // here so that the parameter stays part of the interface.
    assign w_len_hit       = 1'b0;
    assign w_unused_maxlen = (MAX_LEN != 0);
`endif

    assign w_end = s_last | w_len_hit;

    // State register: phase counts cycles spent in CLR and DRAIN, count holds
    // the number of pairs accepted for the current vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLR;
            r_phase <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next-state logic. CLR spans MAC_LAT+1 register cycles so that the first
    // s_ready lands MAC_LAT+1 edges after the entry edge; DRAIN spans
    // MAC_LAT+2 so the capture edge is MAC_LAT+2 after the final accept,
    // leaving the MAC a cycle of margin to fold in the last product.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_count_nxt = r_count;
        case (r_state)
            ST_CLR: begin
                if (r_phase == CLR_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_phase_nxt = '0;
                end else begin
                    w_phase_nxt = r_phase + PH_W'(1);
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    w_count_nxt = w_count_inc;
                    if (w_end) begin
                        w_state_nxt = ST_DRAIN;
                        w_phase_nxt = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (r_phase == DRAIN_LAST) begin
                    w_state_nxt = ST_OUT;
                    w_phase_nxt = '0;
                end else begin
                    w_phase_nxt = r_phase + PH_W'(1);
                end
            end
            ST_OUT: begin
                if (w_result_taken) begin
                    w_state_nxt = ST_CLR;
                    w_phase_nxt = '0;
                    w_count_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_CLR;
                w_phase_nxt = '0;
                w_count_nxt = '0;
            end
        endcase
    end

    // Output logic. Every output is registered, so the values computed here
    // are those that will appear after the coming edge; MAC controls therefore
    // follow the next state. Non-accept cycles feed zeros into the MAC, which
    // adds nothing, so bubbles and the drain never disturb the sum.
    always_comb begin
        w_s_ready_nxt   = (w_state_nxt == ST_RUN);
        w_mac_prstn_nxt = (w_state_nxt != ST_CLR);
        w_mac_acc_nxt   = (w_state_nxt != ST_CLR);
        w_mac_a_nxt     = '0;
        w_mac_b_nxt     = '0;
        w_m_valid_nxt   = r_m_valid;
        w_m_result_nxt  = r_m_result;
        w_m_count_nxt   = r_m_count;
        w_capture       = 1'b0;
        w_busy_nxt      = !((w_state_nxt == ST_RUN) && (w_count_nxt == '0));

        if ((r_state == ST_RUN) && w_accept) begin
            w_mac_a_nxt = s_a;
            w_mac_b_nxt = s_b;
        end

        if ((r_state == ST_DRAIN) && (r_phase == DRAIN_LAST)) begin
            w_capture      = 1'b1;
            w_m_valid_nxt  = 1'b1;
            w_m_result_nxt = mac_c;
            w_m_count_nxt  = r_count;
        end

        if ((r_state == ST_OUT) && w_result_taken) begin
            w_m_valid_nxt = 1'b0;
        end
    end

    // Output registers. busy resets high because reset always lands in CLR.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_ready   <= 1'b0;
            r_mac_prstn <= 1'b0;
            r_mac_acc   <= 1'b0;
            r_mac_a     <= '0;
            r_mac_b     <= '0;
            r_m_valid   <= 1'b0;
            r_m_result  <= '0;
            r_m_count   <= '0;
            r_busy      <= 1'b1;
        end else begin
            r_s_ready   <= w_s_ready_nxt;
            r_mac_prstn <= w_mac_prstn_nxt;
            r_mac_acc   <= w_mac_acc_nxt;
            r_mac_a     <= w_mac_a_nxt;
            r_mac_b     <= w_mac_b_nxt;
            r_m_valid   <= w_m_valid_nxt;
            r_m_result  <= w_m_result_nxt;
            r_m_count   <= w_m_count_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

`ifdef FXP32_DOT_MAXLEN_EN
    logic r_trunc_pend;
    logic r_m_trunc;

    // The truncation flag is decided on the closing accept (limit reached
    // without s_last) and published together with the captured result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trunc_pend <= 1'b0;
            r_m_trunc    <= 1'b0;
        end else begin
            if ((r_state == ST_RUN) && w_accept && w_end) begin
                r_trunc_pend <= w_len_hit & ~s_last;
            end
            if (w_capture) begin
                r_m_trunc <= r_trunc_pend;
            end
        end
    end

    assign m_trunc = r_m_trunc;
`else
    assign m_trunc = 1'b0;
`endif

    assign s_ready   = r_s_ready;
    assign mac_prstn = r_mac_prstn;
    assign mac_acc   = r_mac_acc;
    assign mac_a     = r_mac_a;
    assign mac_b     = r_mac_b;
    assign m_valid   = r_m_valid;
    assign m_result  = r_m_result;
    assign m_count   = r_m_count;
    assign busy      = r_busy;

endmodule
